cnn_infer_ctrl: RTL and testbench
=================================

Name: cnn_infer_ctrl

Overview:
Sequencer in front of generated_cnn. It accepts a 28x28 8-bit image as a byte stream over a valid/ready handshake and assembles the flattened 6272-bit input_image vector. It holds the CNN in reset while loading, then releases it for a fixed latency window. Finally it captures output_logits and presents a class result over a valid/ready handshake.

Parameters:
- PIX_BYTES, 784: bytes per image.
- PIX_W, 8: bits per pixel.
- NUM_CLASSES, 10: width of the CNN output vector.
- CLS_W, 4: width of the class index, at least clog2(NUM_CLASSES).
- LAT_CYCLES, 100: cycles the CNN runs after reset release before capture; legal range 1..65535.

Ports:
- clk, in, 1: system clock, rising edge.
- rst, in, 1: reset, synchronous, active-low.
- pix_valid, in, 1: pixel byte valid.
- pix_data, in, PIX_W: pixel byte.
- pix_ready, out, 1: controller can accept a byte.
- cnn_image, out, PIX_BYTES*PIX_W: drives generated_cnn.input_image.
- cnn_rst, out, 1: drives generated_cnn.rst; active-high.
- cnn_logits, in, NUM_CLASSES: from generated_cnn.output_logits.
- res_valid, out, 1: result available.
- res_ready, in, 1: result consumer ready.
- res_onehot, out, NUM_CLASSES: captured logits vector.
- res_class, out, CLS_W: index of the lowest set bit of res_onehot.
- res_none, out, 1: res_onehot is all zero.
- busy, out, 1: high in RUN and RESULT.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=LOAD, byte_cnt=0, lat_cnt=0, cnn_rst=1, res_valid=0.
  - res_onehot=0, res_class=0, res_none=1, busy=0.
  - cnn_image is not cleared; contents are don't-care until the first frame loads.
- States: LOAD, RUN, RESULT.
- LOAD:
  - pix_ready=1, cnn_rst=1.
  - On pix_valid&&pix_ready, write pix_data to cnn_image[byte_cnt*PIX_W +: PIX_W], so byte 0 lands at the LSBs, then byte_cnt++.
  - When the accepted byte has byte_cnt==PIX_BYTES-1: byte_cnt<=0, lat_cnt<=0, state<=RUN.
- RUN:
  - pix_ready=0, cnn_rst=0, lat_cnt increments every cycle.
  - In the cycle lat_cnt==LAT_CYCLES-1, register cnn_logits into res_onehot, compute res_class/res_none from that value, set res_valid<=1 and state<=RESULT.
  - The first capture edge is exactly LAT_CYCLES cycles after the last byte handshake.
- RESULT:
  - res_valid=1; res_* outputs stay stable while res_ready=0.
  - cnn_rst=0, so the CNN keeps running with the same image.
  - On res_valid&&res_ready: res_valid<=0, cnn_rst<=1, state<=LOAD.
  - pix_ready rises the cycle after the result handshake; no bubble beyond that one cycle.
- Priority encoder: res_class is the lowest index i with res_onehot[i]==1. If no bit is set, res_class=0 and res_none=1.
- Boundaries:
  - pix_valid while in RUN/RESULT is ignored; data is not stored.
  - An all-ones logit vector gives res_class=0.
  - Reset mid-LOAD discards the partial frame: byte_cnt=0, and the next byte goes to the LSBs.
  - Reset in RUN/RESULT drops the pending result.
- Registers: all outputs come straight from registers, except pix_ready and busy, which are decoded from state.

Optional Feature:
- Macro: CNN_INFER_CTRL_PERF_EN.
- With the macro defined:
  - Extra output perf_cycles, out, 32: counts clk cycles from the first byte accepted in a frame up to and including the capture edge.
  - Latched into a register at capture; held through RESULT; cleared by reset.
  - Saturates at 32'hFFFFFFFF.
- Without the macro: the port and counter are absent.

Decomposition:
- Package cnn_ctrl_pkg:
  - state enum {LOAD, RUN, RESULT};
  - default constants PIX_BYTES=784, PIX_W=8, NUM_CLASSES=10;
  - a function lowest_set_idx(vec) returning the class index and none flag.
- One sub-module, cnn_class_enc: purely combinational priority encoder, logits to res_class/res_none, instantiated in front of the capture register.

Test Plan:
- Stream bytes 0x00..0xFF repeating, 784 bytes, pix_valid always high:
  - cnn_image[7:0]==8'h00 and cnn_image[6271:6264]==8'h0F;
  - cnn_rst falls the cycle after byte 783;
  - res_valid rises exactly 100 cycles after the last handshake.
- Stub CNN drives logits 10'b0000100100 at capture -> res_class=2, res_none=0, res_onehot=10'h024.
- Logits 10'h000 -> res_none=1, res_class=0; logits 10'h3FF -> res_class=0.
- Hold res_ready=0 for 50 cycles, toggle cnn_logits, drive pix_valid=1 -> res_* unchanged, pix_ready=0, no writes to cnn_image.
- Deassert rst for 1 cycle after 300 bytes, then stream a full frame -> the new frame's byte 0 is at cnn_image[7:0] and one result is produced.
- Random pix_valid gaps plus back-to-back frames with res_ready=1 -> every frame yields exactly one result. With CNN_INFER_CTRL_PERF_EN and no gaps, perf_cycles==884.

Source files
------------

// File: rtl/cnn_ctrl_pkg.sv
// cnn_ctrl_pkg: shared constants, state encoding and class-index helper for cnn_infer_ctrl
package cnn_ctrl_pkg;
  localparam int PIX_BYTES = 784;
  localparam int PIX_W = 8;
  localparam int NUM_CLASSES = 10;
  localparam int CLS_W = 4;
  localparam int IMG_W = PIX_BYTES * PIX_W;
  localparam int BC_W = $clog2(PIX_BYTES);
  localparam int IDX_W = $clog2(IMG_W);
  localparam int LAT_W = 16;
  typedef enum logic [1:0] {LOAD, RUN, RESULT} state_t;
  typedef struct packed {
    logic [CLS_W-1:0] cls;
    logic none;
  } cls_res_t;
  // lowest set bit wins; an empty vector reports index 0 with none set
  function automatic cls_res_t lowest_set_idx(input logic [NUM_CLASSES-1:0] vec);
    cls_res_t r;
    r.cls = '0;
    r.none = 1'b1;
    for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
      if (vec[i]) begin
        r.cls = CLS_W'(i);
        r.none = 1'b0;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/cnn_infer_ctrl_if.sv
// cnn_infer_ctrl_if: pixel-in and result-out valid/ready handshakes
interface cnn_infer_ctrl_if;
  import cnn_ctrl_pkg::*;
  logic pix_valid;
  logic pix_ready;
  logic [PIX_W-1:0] pix_data;
  logic res_valid;
  logic res_ready;
  logic [NUM_CLASSES-1:0] res_onehot;
  logic [CLS_W-1:0] res_class;
  logic res_none;
  modport slave (
    input pix_valid, pix_data, res_ready,
    output pix_ready, res_valid, res_onehot, res_class, res_none
  );
  modport master (
    output pix_valid, pix_data, res_ready,
    input pix_ready, res_valid, res_onehot, res_class, res_none
  );
endinterface

// File: rtl/cnn_class_enc.sv
// cnn_class_enc: combinational priority encoder from CNN logits to class index
module cnn_class_enc
  import cnn_ctrl_pkg::*;
(
  input  logic [NUM_CLASSES-1:0] logits_i,
  output logic [CLS_W-1:0]       cls_o,
  output logic                   none_o
);
  cls_res_t r;
  assign r = lowest_set_idx(logits_i);
  assign cls_o = r.cls;
  assign none_o = r.none;
endmodule

// File: rtl/cnn_infer_ctrl.sv
// cnn_infer_ctrl: loads an image byte stream, runs the CNN for a fixed window, returns the class; CNN_INFER_CTRL_PERF_EN adds perf_cycles_o
module cnn_infer_ctrl
  import cnn_ctrl_pkg::*;
#(
  parameter int LAT_CYCLES = 100
) (
  input  logic                   clk,
  input  logic                   rst,
  cnn_infer_ctrl_if.slave        bus,
  output logic [IMG_W-1:0]       cnn_image_o,
  output logic                   cnn_rst_o,
  input  logic [NUM_CLASSES-1:0] cnn_logits_i,
  output logic                   busy_o
`ifdef CNN_INFER_CTRL_PERF_EN
  ,
  output logic [31:0]            perf_cycles_o
`endif
);
  state_t state_q, state_d;
  logic [BC_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [IMG_W-1:0] img_q, img_d;
  logic cnn_rst_q, cnn_rst_d;
  logic res_valid_q, res_valid_d;
  logic [NUM_CLASSES-1:0] onehot_q, onehot_d;
  logic [CLS_W-1:0] cls_q, cls_d;
  logic none_q, none_d;
  logic [CLS_W-1:0] enc_cls;
  logic enc_none;
  logic pix_fire, last_byte, cap;
  logic [IDX_W-1:0] pix_off;

  cnn_class_enc u_enc (
    .logits_i (cnn_logits_i),
    .cls_o    (enc_cls),
    .none_o   (enc_none)
  );

  assign pix_fire = (state_q == LOAD) && bus.pix_valid;
  assign last_byte = byte_cnt_q == BC_W'(PIX_BYTES - 1);
  assign cap = (state_q == RUN) && (lat_cnt_q == LAT_W'(LAT_CYCLES - 1));
  assign pix_off = IDX_W'(byte_cnt_q) * IDX_W'(PIX_W);

  // next-state and datapath decode; CNN is held in reset whenever the next state is LOAD
  always_comb begin
    state_d = state_q;
    byte_cnt_d = byte_cnt_q;
    lat_cnt_d = lat_cnt_q;
    img_d = img_q;
    res_valid_d = res_valid_q;
    onehot_d = onehot_q;
    cls_d = cls_q;
    none_d = none_q;
    if (pix_fire) begin
      img_d[pix_off +: PIX_W] = bus.pix_data;
      byte_cnt_d = last_byte ? '0 : byte_cnt_q + 1'b1;
      lat_cnt_d = '0;
      state_d = last_byte ? RUN : LOAD;
    end
    if (state_q == RUN) begin
      lat_cnt_d = lat_cnt_q + 1'b1;
      if (cap) begin
        onehot_d = cnn_logits_i;
        cls_d = enc_cls;
        none_d = enc_none;
        res_valid_d = 1'b1;
        state_d = RESULT;
      end
    end
    if (state_q == RESULT && bus.res_ready) begin
      res_valid_d = 1'b0;
      state_d = LOAD;
    end
    cnn_rst_d = state_d == LOAD;
  end

  // control and result registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= LOAD;
      byte_cnt_q <= '0;
      lat_cnt_q <= '0;
      cnn_rst_q <= 1'b1;
      res_valid_q <= 1'b0;
      onehot_q <= '0;
      cls_q <= '0;
      none_q <= 1'b1;
    end else begin
      state_q <= state_d;
      byte_cnt_q <= byte_cnt_d;
      lat_cnt_q <= lat_cnt_d;
      cnn_rst_q <= cnn_rst_d;
      res_valid_q <= res_valid_d;
      onehot_q <= onehot_d;
      cls_q <= cls_d;
      none_q <= none_d;
    end
  end

  // image buffer is never cleared, only frozen while reset is asserted
  always_ff @(posedge clk) begin
    if (rst) img_q <= img_d;
  end

`ifdef CNN_INFER_CTRL_PERF_EN
  logic [31:0] perf_cnt_q, perf_cnt_d, perf_q, perf_d;
  logic [31:0] perf_inc;
  assign perf_inc = &perf_cnt_q ? perf_cnt_q : perf_cnt_q + 1'b1;

  // frame cycle counter starts on the first accepted byte and is latched at capture
  always_comb begin
    perf_cnt_d = perf_cnt_q;
    perf_d = perf_q;
    if (pix_fire && byte_cnt_q == '0) perf_cnt_d = 32'd1;
    else if ((state_q == LOAD && byte_cnt_q != '0) || state_q == RUN) perf_cnt_d = perf_inc;
    if (cap) perf_d = perf_cnt_d;
  end

  // perf registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_cnt_q <= '0;
      perf_q <= '0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
      perf_q <= perf_d;
    end
  end

  assign perf_cycles_o = perf_q;
`endif

  assign bus.pix_ready = state_q == LOAD;
  assign bus.res_valid = res_valid_q;
  assign bus.res_onehot = onehot_q;
  assign bus.res_class = cls_q;
  assign bus.res_none = none_q;
  assign cnn_image_o = img_q;
  assign cnn_rst_o = cnn_rst_q;
  assign busy_o = state_q != LOAD;
endmodule

// File: tb/tb_cnn_infer_ctrl.sv
// tb_cnn_infer_ctrl: directed frames against a frame-level model of the inference controller
module tb_cnn_infer_ctrl;
  import cnn_ctrl_pkg::*;
  localparam int LAT = 100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [IMG_W-1:0] cnn_image;
  logic cnn_rst;
  logic [NUM_CLASSES-1:0] cnn_logits = '0;
  logic busy;
`ifdef CNN_INFER_CTRL_PERF_EN
  logic [31:0] perf_cycles;
`endif

  cnn_infer_ctrl_if bus();

  cnn_infer_ctrl #(.LAT_CYCLES(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .cnn_image_o  (cnn_image),
    .cnn_rst_o    (cnn_rst),
    .cnn_logits_i (cnn_logits),
    .busy_o       (busy)
`ifdef CNN_INFER_CTRL_PERF_EN
    ,
    .perf_cycles_o(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // frame-level model: phase 0 collecting bytes, 1 waiting out the latency, 2 holding a result
  int m_phase = 0;
  int m_nbytes = 0;
  int m_since = 0;
  bit m_valid = 0;
  logic [NUM_CLASSES-1:0] m_onehot = '0;
  logic [7:0] m_img [PIX_BYTES];
  bit m_known [PIX_BYTES];
  bit started = 0;
  longint m_pcnt = 0;
  longint m_perf = 0;
  int n_res = 0;

  initial for (int i = 0; i < PIX_BYTES; i++) m_known[i] = 0;

  always @(posedge clk) begin
    started = 1;
    if (rst && bus.res_valid && bus.res_ready) n_res++;
    if (!rst) begin
      m_phase = 0;
      m_nbytes = 0;
      m_valid = 0;
      m_onehot = '0;
      m_pcnt = 0;
      m_perf = 0;
    end else if (m_phase == 0) begin
      if (bus.pix_valid) begin
        m_pcnt = (m_nbytes == 0) ? 1 : m_pcnt + 1;
        m_img[m_nbytes] = bus.pix_data;
        m_known[m_nbytes] = 1;
        m_nbytes++;
        if (m_nbytes == PIX_BYTES) begin
          m_nbytes = 0;
          m_since = 0;
          m_phase = 1;
        end
      end else if (m_nbytes > 0) m_pcnt++;
    end else if (m_phase == 1) begin
      m_since++;
      m_pcnt++;
      if (m_since == LAT) begin
        m_onehot = cnn_logits;
        m_valid = 1;
        m_perf = m_pcnt;
        m_phase = 2;
      end
    end else if (bus.res_ready) begin
      m_valid = 0;
      m_phase = 0;
    end
  end

  // compare every cycle on the falling edge
  always @(negedge clk) begin
    int cls;
    bit none;
    bit ok;
    if (started) begin
      chk("pix_ready", bus.pix_ready, m_phase == 0);
      chk("cnn_rst", cnn_rst, m_phase == 0);
      chk("busy", busy, m_phase != 0);
      chk("res_valid", bus.res_valid, m_valid);
      chk("res_onehot", bus.res_onehot, m_onehot);
      none = 1;
      cls = 0;
      for (int i = NUM_CLASSES - 1; i >= 0; i--) if (m_onehot[i]) begin cls = i; none = 0; end
      chk("res_class", bus.res_class, cls);
      chk("res_none", bus.res_none, none);
      ok = 1;
      for (int i = 0; i < PIX_BYTES; i++) if (m_known[i] && cnn_image[i*8 +: 8] !== m_img[i]) ok = 0;
      chk("cnn_image", ok, 1);
`ifdef CNN_INFER_CTRL_PERF_EN
      chk("perf_cycles", perf_cycles, 32'(m_perf));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int base, input int mul, input int gap, input int nbytes, output bit timeout);
    int i = 0;
    int guard = 0;
    bit rdy;
    timeout = 0;
    while (i < nbytes) begin
      if (gap > 0 && $urandom_range(99) < gap) begin
        bus.pix_valid = 1'b0;
        tick();
      end else begin
        bus.pix_valid = 1'b1;
        bus.pix_data = 8'(base + i * mul);
        rdy = bus.pix_ready;
        tick();
        if (rdy) i++;
      end
      guard++;
      if (guard > 20000) begin timeout = 1; break; end
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic wait_result(output int k);
    k = 0;
    while (!bus.res_valid && k < 1000) begin tick(); k++; end
  endtask

  task automatic consume();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic run_frame(input logic [NUM_CLASSES-1:0] lg, input int base);
    bit to;
    int k;
    cnn_logits = lg;
    send_frame(base, 1, 0, PIX_BYTES, to);
    chk("frame_timeout", to, 0);
    wait_result(k);
    chk("frame_latency", k, LAT);
  endtask

  initial begin
    bit to;
    int k, n0, g;
    bus.pix_valid = 1'b0;
    bus.pix_data = '0;
    bus.res_ready = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_none", bus.res_none, 1);
    chk("rst_res_class", bus.res_class, 0);
    chk("rst_res_onehot", bus.res_onehot, 0);
    chk("rst_cnn_rst", cnn_rst, 1);
    chk("rst_pix_ready", bus.pix_ready, 1);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    tick();

    cnn_logits = 10'b0000100100;
    send_frame(0, 1, 0, PIX_BYTES, to);
    chk("f1_timeout", to, 0);
    chk("f1_img_lsb", cnn_image[7:0], 8'h00);
    chk("f1_img_msb", cnn_image[6271:6264], 8'h0F);
    chk("f1_cnn_rst_fall", cnn_rst, 0);
    wait_result(k);
    chk("f1_latency", k, 100);
    chk("f1_class", bus.res_class, 2);
    chk("f1_none", bus.res_none, 0);
    chk("f1_onehot", bus.res_onehot, 10'h024);
`ifdef CNN_INFER_CTRL_PERF_EN
    chk("f1_perf", perf_cycles, 884);
`endif

    for (int j = 0; j < 50; j++) begin
      cnn_logits = 10'($urandom);
      bus.pix_valid = 1'b1;
      bus.pix_data = 8'($urandom);
      tick();
    end
    bus.pix_valid = 1'b0;
    chk("hold_class", bus.res_class, 2);
    chk("hold_onehot", bus.res_onehot, 10'h024);
    chk("hold_pix_ready", bus.pix_ready, 0);
    chk("hold_img_lsb", cnn_image[7:0], 8'h00);
    consume();
    chk("ready_after_hs", bus.pix_ready, 1);

    run_frame(10'h000, 9);
    chk("zero_none", bus.res_none, 1);
    chk("zero_class", bus.res_class, 0);
    consume();

    run_frame(10'h3FF, 33);
    chk("ones_class", bus.res_class, 0);
    chk("ones_none", bus.res_none, 0);
    consume();

    send_frame(8'h55, 1, 0, 300, to);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n0 = n_res;
    cnn_logits = 10'h200;
    send_frame(7, 3, 0, PIX_BYTES, to);
    chk("mid_timeout", to, 0);
    chk("mid_img_lsb", cnn_image[7:0], 8'h07);
    wait_result(k);
    chk("mid_class", bus.res_class, 9);
    consume();
    repeat (5) tick();
    chk("mid_one_result", n_res - n0, 1);

    bus.res_ready = 1'b1;
    n0 = n_res;
    for (int f = 0; f < 3; f++) begin
      cnn_logits = 10'(1 << (f * 3 + 1));
      send_frame(f * 17, 5, 30, PIX_BYTES, to);
      chk("gap_timeout", to, 0);
    end
    g = 0;
    while (n_res - n0 < 3 && g < 3000) begin tick(); g++; end
    repeat (5) tick();
    chk("gap_results", n_res - n0, 3);
    bus.res_ready = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
